montinv_sched: RTL

Round-robin scheduler that shares one Montgomery-inverse phase-2 unit (`montinvp2`) between `NREQ` ECC datapath requesters, such as the point-add and point-double engines. It captures one requester's operands, issues a single-cycle start to the inverter and waits for its done pulse. It then returns the result to the owning requester with a held valid/ack handshake. A watchdog and an exponent range check flag abnormal jobs, so a requester never hangs.

---
 rtl/montinv_sched_if.sv | 41 ++++
 rtl/montinv_sched.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/montinv_sched_if.sv
// montinv_sched_if: bundle of the requester-side and inverter-side signals of
// the shared Montgomery-inverse scheduler.
//   slave  : the scheduler (montinv_sched)
//   master : the environment (requesters + phase-2 inverter)
// Requester side : req, req_ainv, req_exp, mod -> gnt, rsp_vld, rsp_inv,
//                  rsp_err, busy; rsp_ack back in.
// Inverter side  : inv_en, inv_ainv, inv_mod, inv_exp out; inv_res, inv_vld in.
interface montinv_sched_if #(
    parameter int WIDTH = 256,
    parameter int CWID  = 10,
    parameter int NREQ  = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_ainv;
    logic [NREQ*CWID-1:0]  req_exp;
    logic [WIDTH-1:0]      mod;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       rsp_vld;
    logic [WIDTH-1:0]      rsp_inv;
    logic                  rsp_err;
    logic [NREQ-1:0]       rsp_ack;
    logic                  busy;
    logic                  inv_en;
    logic [WIDTH-1:0]      inv_ainv;
    logic [WIDTH-1:0]      inv_mod;
    logic [CWID-1:0]       inv_exp;
    logic [WIDTH-1:0]      inv_res;
    logic                  inv_vld;

    modport slave (
        input  req, req_ainv, req_exp, mod, rsp_ack, inv_res, inv_vld,
        output gnt, rsp_vld, rsp_inv, rsp_err, busy,
               inv_en, inv_ainv, inv_mod, inv_exp
    );

    modport master (
        output req, req_ainv, req_exp, mod, rsp_ack, inv_res, inv_vld,
        input  gnt, rsp_vld, rsp_inv, rsp_err, busy,
               inv_en, inv_ainv, inv_mod, inv_exp
    );
endinterface

// File: rtl/montinv_sched.sv
// montinv_sched: round-robin arbiter that shares one Montgomery-inverse
// phase-2 unit between NREQ requesters. One job at a time:
//   IDLE  -> capture winner's operands, pulse gnt
//   ISSUE -> inv_en for one cycle
//   WAIT  -> wait for inv_vld, or give up after TMO cycles
//   RESP  -> hold rsp_vld[owner] until rsp_ack[owner]
// Ports: clk, rst (synchronous, active-high), bus (montinv_sched_if.slave).
// All bus outputs are registered.
module montinv_sched #(
    parameter int WIDTH = 256,
    parameter int CWID  = 10,
    parameter int NREQ  = 2,
    parameter int TMO   = 2*WIDTH+8
) (
    input  logic             clk,
    input  logic             rst,
    montinv_sched_if.slave   bus
);
    localparam int              IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int              TW    = $clog2(TMO+1);
    localparam logic [IW-1:0]   LAST0 = IW'(NREQ-1);
    localparam logic [TW-1:0]   TLAST = TW'(TMO-1);
    localparam logic [CWID-1:0] EMIN  = CWID'(WIDTH);
    localparam logic [CWID-1:0] EMAX  = CWID'(2*WIDTH);
    localparam logic [NREQ-1:0] ONE   = NREQ'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_nxt;

    logic [IW-1:0]   last, owner, win;
    logic            found;
    logic [CWID-1:0] win_exp;
    logic            win_bad;
    logic [TW-1:0]   wcnt;
    logic            bad_exp;

    logic [NREQ-1:0]  gnt_q, rsp_vld_q;
    logic [WIDTH-1:0] rsp_inv_q, inv_ainv_q, inv_mod_q;
    logic [CWID-1:0]  inv_exp_q;
    logic             rsp_err_q, busy_q, inv_en_q;

    // Round-robin pick: scan from last+NREQ down to last+1 so the nearest
    // requester after last is the final (winning) assignment.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (bus.req[(int'(last) + k) % NREQ]) begin
                win   = IW'((int'(last) + k) % NREQ);
                found = 1'b1;
            end
        end
    end

    // Out-of-range exponents are replaced by WIDTH (zero halvings) and the
    // job is flagged so the response carries rsp_err.
    always_comb begin
        win_exp = bus.req_exp[int'(win)*CWID +: CWID];
        win_bad = (win_exp < EMIN) || (win_exp > EMAX);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (bus.inv_vld || (wcnt == TLAST)) state_nxt = RESP;
            RESP:    if (bus.rsp_ack[owner]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last       <= LAST0;
            owner      <= '0;
            wcnt       <= '0;
            bad_exp    <= 1'b0;
            gnt_q      <= '0;
            rsp_vld_q  <= '0;
            rsp_inv_q  <= '0;
            rsp_err_q  <= 1'b0;
            busy_q     <= 1'b0;
            inv_en_q   <= 1'b0;
            inv_ainv_q <= '0;
            inv_mod_q  <= '0;
            inv_exp_q  <= '0;
        end else begin
            gnt_q    <= '0;
            inv_en_q <= 1'b0;
            busy_q   <= (state_nxt != IDLE);
            case (state)
                IDLE: if (found) begin
                    owner      <= win;
                    last       <= win;
                    gnt_q      <= ONE << win;
                    // inv_en rises together with gnt, i.e. during ISSUE
                    inv_en_q   <= 1'b1;
                    inv_ainv_q <= bus.req_ainv[int'(win)*WIDTH +: WIDTH];
                    inv_mod_q  <= bus.mod;
                    inv_exp_q  <= win_bad ? EMIN : win_exp;
                    bad_exp    <= win_bad;
                end
                ISSUE: wcnt <= '0;
                WAIT: begin
                    wcnt <= wcnt + TW'(1);
                    // a done pulse in the timeout cycle still counts as done
                    if (bus.inv_vld) begin
                        rsp_inv_q <= bus.inv_res;
                        rsp_err_q <= bad_exp;
                        rsp_vld_q <= ONE << owner;
                    end else if (wcnt == TLAST) begin
                        rsp_inv_q <= '0;
                        rsp_err_q <= 1'b1;
                        rsp_vld_q <= ONE << owner;
                    end
                end
                RESP: if (bus.rsp_ack[owner]) begin
                    rsp_vld_q <= '0;
                    rsp_err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.rsp_vld  = rsp_vld_q;
    assign bus.rsp_inv  = rsp_inv_q;
    assign bus.rsp_err  = rsp_err_q;
    assign bus.busy     = busy_q;
    assign bus.inv_en   = inv_en_q;
    assign bus.inv_ainv = inv_ainv_q;
    assign bus.inv_mod  = inv_mod_q;
    assign bus.inv_exp  = inv_exp_q;
endmodule
